// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with line-fill memory port.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module cache_ctrl_dm #(
  parameter int NUM_LINES    = 8,
  parameter int WRITE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_bw,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_hold_o,
  output logic [31:0]   mem_addr,
  inout  wire  [31:0]   mem_data,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic          mem_bw,
  output logic          mem_multiple_read,
  input  logic [255:0]  mem_line_i,
  input  logic          mem_line_full_i,
  input  logic          mem_hold_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;
  localparam int WC_W  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WDONE} state_t;

  state_t             r_state, w_state_nx;
  logic [255:0]       r_data [NUM_LINES];
  logic [TAG_W-1:0]   r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic               r_fill_started;
  logic [WC_W-1:0]    r_wcnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_bw;
  logic [31:0]        r_rdata;

  logic [IDX_W-1:0]   w_idx, w_lidx;
  logic [TAG_W-1:0]   w_tag, w_ltag;
  logic               w_hit, w_lhit;
  logic               w_rd_hit, w_start, w_fill_done, w_wr_done;
  logic [31:0]        w_rword;

  // CPU-side lookup uses the live address; the transaction side uses the latched one.
  assign w_idx    = cpu_addr[5 +: IDX_W];
  assign w_tag    = cpu_addr[31 -: TAG_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lidx   = r_addr[5 +: IDX_W];
  assign w_ltag   = r_addr[31 -: TAG_W];
  assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign w_rword  = r_data[w_idx][{cpu_addr[4:2], 5'b0} +: 32];

  assign w_rd_hit    = (r_state == S_IDLE) && cpu_req && !cpu_we && w_hit;
  assign w_start     = (r_state == S_IDLE) && cpu_req && (cpu_we || !w_hit);
  assign w_fill_done = (r_state == S_FILL) && r_fill_started && !mem_line_full_i && !mem_hold_i;
  assign w_wr_done   = (r_state == S_WRITE) && (r_wcnt == '0);

  assign cpu_rdata = w_rd_hit ? w_rword : r_rdata;
  assign mem_data  = (r_state == S_WRITE) ? r_wdata : 'z;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req) begin
                 if (cpu_we)      w_state_nx = S_WRITE;
                 else if (!w_hit) w_state_nx = S_FILL;
               end
      S_FILL:  if (w_fill_done) w_state_nx = S_IDLE;
      S_WRITE: if (r_wcnt == '0) w_state_nx = S_WDONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ce_n          = 1'b1;
    mem_oe_n          = 1'b1;
    mem_we_n          = 1'b1;
    mem_bw            = 1'b1;
    mem_multiple_read = 1'b1;
    mem_addr          = 32'h0;
    cpu_hold_o        = 1'b0;
    case (r_state)
      S_IDLE:  cpu_hold_o = cpu_req && (cpu_we || !w_hit);
      S_FILL: begin
        mem_ce_n          = 1'b0;
        mem_oe_n          = 1'b0;
        mem_multiple_read = 1'b0;
        mem_addr          = {r_addr[31:5], 5'b0};
        cpu_hold_o        = 1'b1;
      end
      S_WRITE: begin
        mem_ce_n   = 1'b0;
        mem_we_n   = 1'b0;
        mem_bw     = r_bw;
        mem_addr   = r_addr;
        cpu_hold_o = 1'b1;
      end
      default: cpu_hold_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= '0;
      r_fill_started <= 1'b0;
      r_wcnt         <= '0;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_bw           <= 1'b0;
      r_rdata        <= 32'h0;
    end else begin
      if (w_start) begin
        r_addr <= cpu_addr;
        if (cpu_we) begin
          r_wdata <= cpu_wdata;
          r_bw    <= cpu_bw;
          r_wcnt  <= WC_W'(WRITE_CYCLES - 1);
        end
      end
      if (r_state == S_FILL) begin
        if (w_fill_done)         r_fill_started <= 1'b0;
        else if (!r_fill_started) r_fill_started <= 1'b1;
      end
      if (w_fill_done)   r_valid[w_lidx] <= 1'b1;
      if ((r_state == S_WRITE) && (r_wcnt != '0)) r_wcnt <= r_wcnt - 1'b1;
      if (w_rd_hit)      r_rdata <= w_rword;
    end
  end

  // NOTE: line data and tags carry no reset; the valid bits alone make them meaningful.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_lidx] <= mem_line_i;
      r_tag[w_lidx]  <= w_ltag;
    end else if (w_wr_done && w_lhit) begin
      if (r_bw) r_data[w_lidx][{r_addr[4:2], 5'b0} +: 32] <= r_wdata;
      else      r_data[w_lidx][{r_addr[4:0], 3'b0} +: 8]  <= r_wdata[7:0];
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
    end else begin
      if (w_rd_hit && (hit_cnt_o != 32'hFFFF_FFFF))                 hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (w_start && !cpu_we && (miss_cnt_o != 32'hFFFF_FFFF))      miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
